// File: rtl/parity_frame_scheduler.sv
// -----------------------------------------------------------------------------
// parity_frame_scheduler
//
// Shares one bit-serial parity datapath among NREQ word requesters. A
// round-robin arbiter picks one pending requester, captures its WIDTH-bit
// word, and shifts the word out LSB-first on ser_bit/ser_valid. The word's
// parity is accumulated while it shifts and is reported, together with the
// requester index, on a one-cycle done pulse at the end of the frame.
//
// Configuration macro: PARITY_FRAME_ODD_EN
//   defined   -> odd parity  (parity = ~^word)
//   undefined -> even parity (parity =  ^word)
//   Frame timing is identical in both builds.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; clears all state immediately
//   req        in   [NREQ]        per-requester request level
//   data       in   [NREQ*WIDTH]  requester i word at data[i*WIDTH +: WIDTH]
//   grant      out  [NREQ]        one-hot, one-cycle grant pulse
//   ser_bit    out  current serial bit, LSB first
//   ser_valid  out  ser_bit is valid
//   busy       out  high while a frame is in progress (GRANT/SHIFT/DONE)
//   done       out  one-cycle pulse at frame end
//   done_id    out  [IDW]  index of the completed requester, valid with done
//   parity     out  parity of the completed word, valid with done
//   dbg_state  out  [2]    current FSM state (IDLE=0, GRANT=1, SHIFT=2, DONE=3)
//
// Handshake: a requester holds req[i] high and data stable until it sees
// grant[i]; the word is captured on the edge that raises grant[i], and the
// requester drops req[i] during the grant cycle. req/data are only looked at
// in IDLE, so changes during GRANT/SHIFT/DONE have no effect. A req still high
// when the scheduler returns to IDLE counts as a fresh request and is
// arbitrated after the other pending requesters.
//
// All outputs are registered. Frame timeline relative to the grant cycle G:
//   G: grant pulse, G+1..G+WIDTH: serial bits, G+WIDTH+1: done.
// -----------------------------------------------------------------------------
module parity_frame_scheduler #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         grant,
  output logic                    ser_bit,
  output logic                    ser_valid,
  output logic                    busy,
  output logic                    done,
  output logic [IDW-1:0]          done_id,
  output logic                    parity,
  output logic [1:0]              dbg_state
);

  localparam int CW = $clog2(WIDTH);

`ifdef PARITY_FRAME_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_sr, w_sr;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic             r_acc, w_acc;
  logic [IDW-1:0]   r_id, w_id;
  logic [IDW-1:0]   r_last, w_last;
  logic [NREQ-1:0]  r_grant, w_grant;
  logic             r_ser_bit, w_ser_bit;
  logic             r_ser_valid, w_ser_valid;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic [IDW-1:0]   r_done_id, w_done_id;
  logic             r_parity, w_parity;

  // Round-robin pick: first set request scanning from the one after the
  // last granted requester, wrapping around.
  logic             w_found;
  logic [IDW-1:0]   w_sel;

  always_comb begin
    int             v_idx;
    logic [IDW-1:0] v_pos;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = 0;
    v_pos   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      v_idx = int'(r_last) + k;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      v_pos = IDW'(v_idx);
      if (!w_found && req[v_pos]) begin
        w_found = 1'b1;
        w_sel   = v_pos;
      end
    end
  end

  // Next-state and next-output logic; every output register is loaded with
  // the value it must show in the state being entered.
  always_comb begin
    w_state     = r_state;
    w_sr        = r_sr;
    w_cnt       = r_cnt;
    w_acc       = r_acc;
    w_id        = r_id;
    w_last      = r_last;
    w_grant     = '0;
    w_ser_bit   = 1'b0;
    w_ser_valid = 1'b0;
    w_done      = 1'b0;
    w_done_id   = r_done_id;
    w_parity    = r_parity;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state = S_GRANT;
          w_grant = NREQ'(1) << w_sel;
          w_sr    = data[int'(w_sel)*WIDTH +: WIDTH];
          w_cnt   = '0;
          w_acc   = 1'b0;
          w_id    = w_sel;
          w_last  = w_sel;
        end
      end
      S_GRANT: begin
        w_state     = S_SHIFT;
        w_ser_valid = 1'b1;
        w_ser_bit   = r_sr[0];
      end
      S_SHIFT: begin
        w_sr  = r_sr >> 1;
        w_acc = r_acc ^ r_sr[0];
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH-1)) begin
          // Last bit leaves this edge; fold it into the reported parity.
          w_state   = S_DONE;
          w_done    = 1'b1;
          w_done_id = r_id;
          w_parity  = r_acc ^ r_sr[0] ^ ODD;
        end else begin
          w_ser_valid = 1'b1;
          w_ser_bit   = r_sr[1];
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_acc       <= 1'b0;
      r_id        <= '0;
      r_last      <= IDW'(NREQ-1);
      r_grant     <= '0;
      r_ser_bit   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= '0;
      r_parity    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sr        <= w_sr;
      r_cnt       <= w_cnt;
      r_acc       <= w_acc;
      r_id        <= w_id;
      r_last      <= w_last;
      r_grant     <= w_grant;
      r_ser_bit   <= w_ser_bit;
      r_ser_valid <= w_ser_valid;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_done_id   <= w_done_id;
      r_parity    <= w_parity;
    end
  end

  assign grant     = r_grant;
  assign ser_bit   = r_ser_bit;
  assign ser_valid = r_ser_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign done_id   = r_done_id;
  assign parity    = r_parity;
  assign dbg_state = r_state;

endmodule
